// File: rtl/sht40_rx_checker.sv
// Rebuilds the 6-byte SHT40 reply from the I2C master's byte counter, checks each word's
// CRC-8 bit-serially and publishes raw temperature/humidity; CRC mismatch aborts the receive.
module sht40_rx_checker #(
    parameter int unsigned NUM_BYTES = 6,
    parameter logic [7:0]  CRC_POLY  = 8'h31,
    parameter logic [7:0]  CRC_INIT  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Bytes_Received,
    input  logic [7:0]  Data_Received,
    input  logic [2:0]  Master_State_Out,
    output logic        CRC_Error_Out,
    output logic        Rx_Overrun,
    output logic [15:0] Temp_Raw,
    output logic [15:0] Humidity_Raw,
    output logic        Sample_Valid,
    output logic        Frame_Busy
);

    localparam int unsigned IDX_W = (NUM_BYTES > 6) ? $clog2(NUM_BYTES + 1) : 3;
    localparam logic [IDX_W-1:0] IDX_T_MSB = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_T_CRC = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_H_MSB = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_H_CRC = IDX_W'(5);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_BYTES);
    localparam logic [2:0]       MASTER_START = 3'b001;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CMP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       sh_q, sh_d;
    logic [15:0]      word_q, word_d;
    logic [15:0]      temp_hold_q, temp_hold_d;
    logic             temp_ok_q, temp_ok_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             crc_err_q, crc_err_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      temp_raw_q, temp_raw_d;
    logic [15:0]      hum_raw_q, hum_raw_d;
    logic             sample_valid_q, sample_valid_d;
    logic             frame_busy_q, frame_busy_d;
    logic             strobe;
    logic             fb;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        bit_cnt_d      = bit_cnt_q;
        crc_d          = crc_q;
        sh_d           = sh_q;
        word_d         = word_q;
        temp_hold_d    = temp_hold_q;
        temp_ok_d      = temp_ok_q;
        crc_err_d      = crc_err_q;
        overrun_d      = overrun_q;
        temp_raw_d     = temp_raw_q;
        hum_raw_d      = hum_raw_q;
        sample_valid_d = 1'b0;
        frame_busy_d   = frame_busy_q;
        fb             = 1'b0;
        cnt_d          = Bytes_Received;
        // Any counter movement is one byte, so wraps and multi-step jumps are covered.
        strobe         = (Bytes_Received != cnt_q);

        if (Master_State_Out == MASTER_START) begin
            state_d      = ST_IDLE;
            idx_d        = IDX_T_MSB;
            crc_d        = CRC_INIT;
            frame_busy_d = 1'b0;
            crc_err_d    = 1'b0;
            overrun_d    = 1'b0;
            temp_ok_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strobe && (idx_q < IDX_END)) begin
                        sh_d = Data_Received;
                        if ((idx_q == IDX_T_CRC) || (idx_q == IDX_H_CRC)) begin
                            state_d = ST_CMP;
                        end else begin
                            state_d   = ST_SHIFT;
                            bit_cnt_d = 3'd0;
                            word_d    = {word_q[7:0], Data_Received};
                            idx_d     = idx_q + 1'b1;
                            if ((idx_q == IDX_T_MSB) || (idx_q == IDX_H_MSB)) begin
                                crc_d = CRC_INIT;
                            end
                            if (idx_q == IDX_T_MSB) begin
                                frame_busy_d = 1'b1;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (strobe) begin
                        overrun_d = 1'b1;
                    end
                    fb        = crc_q[7] ^ sh_q[7];
                    crc_d     = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
                    sh_d      = {sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMP: begin
                    if (strobe) begin
                        overrun_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    if (sh_q == crc_q) begin
                        if (idx_q == IDX_T_CRC) begin
                            temp_hold_d = word_q;
                            temp_ok_d   = 1'b1;
                            crc_d       = CRC_INIT;
                            idx_d       = IDX_H_MSB;
                        end else begin
                            // Publish both words together so a reader never sees a mixed pair.
                            if (temp_ok_q) begin
                                temp_raw_d     = temp_hold_q;
                                hum_raw_d      = word_q;
                                sample_valid_d = 1'b1;
                            end
                            frame_busy_d = 1'b0;
                            idx_d        = IDX_END;
                        end
                    end else begin
                        crc_err_d    = 1'b1;
                        frame_busy_d = 1'b0;
                        idx_d        = IDX_END;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= IDX_T_MSB;
            bit_cnt_q      <= 3'd0;
            crc_q          <= CRC_INIT;
            sh_q           <= 8'h00;
            word_q         <= 16'h0000;
            temp_hold_q    <= 16'h0000;
            temp_ok_q      <= 1'b0;
            cnt_q          <= Bytes_Received;
            crc_err_q      <= 1'b0;
            overrun_q      <= 1'b0;
            temp_raw_q     <= 16'h0000;
            hum_raw_q      <= 16'h0000;
            sample_valid_q <= 1'b0;
            frame_busy_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bit_cnt_q      <= bit_cnt_d;
            crc_q          <= crc_d;
            sh_q           <= sh_d;
            word_q         <= word_d;
            temp_hold_q    <= temp_hold_d;
            temp_ok_q      <= temp_ok_d;
            cnt_q          <= cnt_d;
            crc_err_q      <= crc_err_d;
            overrun_q      <= overrun_d;
            temp_raw_q     <= temp_raw_d;
            hum_raw_q      <= hum_raw_d;
            sample_valid_q <= sample_valid_d;
            frame_busy_q   <= frame_busy_d;
        end
    end

    assign CRC_Error_Out = crc_err_q;
    assign Rx_Overrun    = overrun_q;
    assign Temp_Raw      = temp_raw_q;
    assign Humidity_Raw  = hum_raw_q;
    assign Sample_Valid  = sample_valid_q;
    assign Frame_Busy    = frame_busy_q;

endmodule

// File: tb/tb_sht40_rx_checker.sv
// Bench for sht40_rx_checker: directed SHT40 reply scenarios plus randomized frames
// scored against a transaction-level model of the reply format.
module tb_sht40_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Bytes_Received;
    logic [7:0]  Data_Received;
    logic [2:0]  Master_State_Out;
    logic        CRC_Error_Out;
    logic        Rx_Overrun;
    logic [15:0] Temp_Raw;
    logic [15:0] Humidity_Raw;
    logic        Sample_Valid;
    logic        Frame_Busy;

    int total = 0;
    int bad   = 0;
    int sv_pulses = 0;
    logic [3:0] cnt = 4'd0;

    // Reference model state (one reply frame at a time)
    int          m_idx;
    logic [7:0]  m_b [6];
    logic        m_err, m_ovr, m_tok;
    logic [15:0] m_temp, m_hum;
    int          m_samples = 0;

    sht40_rx_checker dut (
        .clk              (clk),
        .rst              (rst),
        .Bytes_Received   (Bytes_Received),
        .Data_Received    (Data_Received),
        .Master_State_Out (Master_State_Out),
        .CRC_Error_Out    (CRC_Error_Out),
        .Rx_Overrun       (Rx_Overrun),
        .Temp_Raw         (Temp_Raw),
        .Humidity_Raw     (Humidity_Raw),
        .Sample_Valid     (Sample_Valid),
        .Frame_Busy       (Frame_Busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (Sample_Valid === 1'b1) sv_pulses++;

    // CRC-8/SHT: remainder of {a,b} under x^8+x^5+x^4+1, seed 0xFF
    function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] msg;
        logic [7:0]  c;
        msg = {a, b};
        c   = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ msg[i]) c = (c << 1) ^ 8'h31;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic strobe(input logic [3:0] step, input logic [7:0] b);
        @(posedge clk); #1;
        cnt = cnt + step;
        Bytes_Received = cnt;
        Data_Received  = b;
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        Master_State_Out = 3'b001;
        @(posedge clk); #1;
        Master_State_Out = 3'b000;
    endtask

    task automatic model_reset_frame();
        m_idx = 0; m_err = 1'b0; m_ovr = 1'b0; m_tok = 1'b0;
    endtask

    // injected: byte arrives while the engine is still busy with the previous data byte
    task automatic model_byte(input logic [7:0] b, input bit injected, output bit took_data);
        took_data = 1'b0;
        if (injected) begin
            m_ovr = 1'b1;
        end else if (m_idx < 6) begin
            if (m_idx == 2 || m_idx == 5) begin
                if (b == crc8(m_b[m_idx-2], m_b[m_idx-1])) begin
                    if (m_idx == 2) begin
                        m_tok = 1'b1;
                        m_idx = 3;
                    end else begin
                        if (m_tok) begin
                            m_temp = {m_b[0], m_b[1]};
                            m_hum  = {m_b[3], m_b[4]};
                            m_samples++;
                        end
                        m_idx = 6;
                    end
                end else begin
                    m_err = 1'b1;
                    m_idx = 6;
                end
            end else begin
                m_b[m_idx] = b;
                m_idx++;
                took_data = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt = 4'd5; Bytes_Received = cnt;
        Data_Received = 8'h00; Master_State_Out = 3'b000;
        tick(3); #1;
        cnt = 4'd9; Bytes_Received = cnt;
        @(posedge clk); #1;
        total++; if ({CRC_Error_Out, Rx_Overrun, Sample_Valid, Frame_Busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {CRC_Error_Out, Rx_Overrun, Sample_Valid, Frame_Busy});
        end
        total++; if (Temp_Raw !== 16'h0000) begin
            bad++; $display("FAIL reset_temp: got %h want 0000", Temp_Raw);
        end
        total++; if (Humidity_Raw !== 16'h0000) begin
            bad++; $display("FAIL reset_hum: got %h want 0000", Humidity_Raw);
        end
        rst = 1'b0;
        tick(3); #1;
        total++; if (Frame_Busy !== 1'b0) begin
            bad++; $display("FAIL reset_no_strobe: got busy=%b want 0", Frame_Busy);
        end
    endtask

    task automatic test_good_frames();
        logic [7:0]  fr [2][6];
        logic [15:0] et [2];
        logic [15:0] eh [2];
        int p0;
        fr[0] = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92}; et[0] = 16'hBEEF; eh[0] = 16'hBEEF;
        fr[1] = '{8'h00, 8'h00, 8'h81, 8'h12, 8'h34, 8'h37}; et[1] = 16'h0000; eh[1] = 16'h1234;
        for (int f = 0; f < 2; f++) begin
            frame_start();
            p0 = sv_pulses;
            for (int k = 0; k < 6; k++) begin
                strobe(4'd1, fr[f][k]);
                if (k == 0) begin
                    @(posedge clk); #1;
                    total++; if (Frame_Busy !== 1'b1) begin
                        bad++; $display("FAIL good_busy_start[%0d]: got %b want 1", f, Frame_Busy);
                    end
                    tick(8);
                end else if (k < 5) begin
                    tick(9);
                end else begin
                    @(posedge clk); #1;
                    total++; if (Sample_Valid !== 1'b0) begin
                        bad++; $display("FAIL good_sv_t1[%0d]: got %b want 0", f, Sample_Valid);
                    end
                    @(posedge clk); #1;
                    total++; if (Sample_Valid !== 1'b1) begin
                        bad++; $display("FAIL good_sv_t2[%0d]: got %b want 1", f, Sample_Valid);
                    end
                    total++; if (Temp_Raw !== et[f] || Humidity_Raw !== eh[f]) begin
                        bad++; $display("FAIL good_words[%0d]: got %h/%h want %h/%h", f, Temp_Raw, Humidity_Raw, et[f], eh[f]);
                    end
                    total++; if (Frame_Busy !== 1'b0) begin
                        bad++; $display("FAIL good_busy_end[%0d]: got %b want 0", f, Frame_Busy);
                    end
                    tick(3); #1;
                end
            end
            total++; if (sv_pulses - p0 !== 1) begin
                bad++; $display("FAIL good_pulses[%0d]: got %0d want 1", f, sv_pulses - p0);
            end
            total++; if ({CRC_Error_Out, Rx_Overrun} !== 2'b00) begin
                bad++; $display("FAIL good_flags[%0d]: got %b want 00", f, {CRC_Error_Out, Rx_Overrun});
            end
        end
    endtask

    task automatic test_crc_error();
        logic [7:0] fr [6];
        int p0;
        fr = '{8'hBE, 8'hEF, 8'h93, 8'hBE, 8'hEF, 8'h92};
        frame_start();
        p0 = sv_pulses;
        for (int k = 0; k < 6; k++) begin
            strobe(4'd1, fr[k]);
            if (k == 2) begin
                @(posedge clk); #1;
                total++; if (CRC_Error_Out !== 1'b0) begin
                    bad++; $display("FAIL crcerr_t1: got %b want 0", CRC_Error_Out);
                end
                @(posedge clk); #1;
                total++; if (CRC_Error_Out !== 1'b1 || Frame_Busy !== 1'b0) begin
                    bad++; $display("FAIL crcerr_t2: got err=%b busy=%b want err=1 busy=0", CRC_Error_Out, Frame_Busy);
                end
                tick(8);
            end else begin
                tick(9);
            end
        end
        #1;
        total++; if (sv_pulses - p0 !== 0) begin
            bad++; $display("FAIL crcerr_pulses: got %0d want 0", sv_pulses - p0);
        end
        total++; if (Temp_Raw !== 16'h0000 || Humidity_Raw !== 16'h1234) begin
            bad++; $display("FAIL crcerr_hold: got %h/%h want 0000/1234", Temp_Raw, Humidity_Raw);
        end
        total++; if (CRC_Error_Out !== 1'b1 || Rx_Overrun !== 1'b0) begin
            bad++; $display("FAIL crcerr_sticky: got err=%b ovr=%b want err=1 ovr=0", CRC_Error_Out, Rx_Overrun);
        end
        frame_start();
        total++; if (CRC_Error_Out !== 1'b0) begin
            bad++; $display("FAIL crcerr_clear: got %b want 0", CRC_Error_Out);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] rest [4];
        bit took;
        int p0;
        rest = '{8'h92, 8'hBE, 8'hEF, 8'h92};
        frame_start();
        model_reset_frame();
        p0 = sv_pulses;
        strobe(4'd1, 8'hBE); model_byte(8'hBE, 1'b0, took);
        tick(2);
        strobe(4'd1, 8'hEF); model_byte(8'hEF, 1'b1, took);
        @(posedge clk); #1;
        total++; if (Rx_Overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_flag: got %b want 1", Rx_Overrun);
        end
        tick(5);
        for (int k = 0; k < 4; k++) begin
            strobe(4'd1, rest[k]); model_byte(rest[k], 1'b0, took);
            tick(9);
        end
        #1;
        total++; if (sv_pulses - p0 !== 0) begin
            bad++; $display("FAIL ovr_pulses: got %0d want 0", sv_pulses - p0);
        end
        total++; if (CRC_Error_Out !== m_err || Rx_Overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_flags: got err=%b ovr=%b want err=%b ovr=1", CRC_Error_Out, Rx_Overrun, m_err);
        end
        total++; if (Frame_Busy !== (m_idx > 0 && m_idx < 6)) begin
            bad++; $display("FAIL ovr_busy: got %b want %b", Frame_Busy, (m_idx > 0 && m_idx < 6));
        end
        frame_start();
        total++; if (Rx_Overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_clear: got %b want 0", Rx_Overrun);
        end
    endtask

    task automatic test_start_priority();
        logic [7:0] fr [6];
        int p0;
        fr = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37};
        @(posedge clk); #1;
        Master_State_Out = 3'b001;
        cnt = cnt + 4'd1; Bytes_Received = cnt; Data_Received = 8'hBE;
        @(posedge clk); #1;
        Master_State_Out = 3'b000;
        total++; if (Frame_Busy !== 1'b0) begin
            bad++; $display("FAIL start_drops_byte: got busy=%b want 0", Frame_Busy);
        end
        p0 = sv_pulses;
        for (int k = 0; k < 6; k++) begin
            strobe(4'd1, fr[k]);
            tick(9);
        end
        #1;
        total++; if (sv_pulses - p0 !== 1 || Temp_Raw !== 16'hBEEF || Humidity_Raw !== 16'h1234) begin
            bad++; $display("FAIL start_frame: got n=%0d %h/%h want n=1 beef/1234", sv_pulses - p0, Temp_Raw, Humidity_Raw);
        end
    endtask

    task automatic test_wrap_reset();
        logic [7:0] fa [6];
        logic [7:0] fb [6];
        int p0;
        fa = '{8'hBE, 8'hEF, 8'h92, 8'h00, 8'h00, 8'h81};
        fb = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37};
        @(posedge clk); #1;
        rst = 1'b1; cnt = 4'd14; Bytes_Received = cnt;
        tick(2); #1;
        rst = 1'b0;
        p0 = sv_pulses;
        for (int k = 0; k < 6; k++) begin
            strobe(4'd1, fa[k]);
            tick(9);
        end
        #1;
        total++; if (sv_pulses - p0 !== 1 || Temp_Raw !== 16'hBEEF || Humidity_Raw !== 16'h0000 || CRC_Error_Out !== 1'b0) begin
            bad++; $display("FAIL wrap_frame: got n=%0d %h/%h err=%b want n=1 beef/0000 err=0", sv_pulses - p0, Temp_Raw, Humidity_Raw, CRC_Error_Out);
        end
        frame_start();
        strobe(4'd1, 8'hBE);
        tick(9);
        strobe(4'd1, 8'hEF);
        tick(2); #1;
        rst = 1'b1;
        cnt = cnt + 4'd1; Bytes_Received = cnt;
        @(posedge clk); #1;
        total++; if ({CRC_Error_Out, Rx_Overrun, Sample_Valid, Frame_Busy} !== 4'b0000 || Temp_Raw !== 16'h0000 || Humidity_Raw !== 16'h0000) begin
            bad++; $display("FAIL shift_reset: got flags=%b %h/%h want 0000 0000/0000", {CRC_Error_Out, Rx_Overrun, Sample_Valid, Frame_Busy}, Temp_Raw, Humidity_Raw);
        end
        rst = 1'b0;
        tick(2); #1;
        total++; if (Frame_Busy !== 1'b0 || Rx_Overrun !== 1'b0) begin
            bad++; $display("FAIL shift_reset_no_strobe: got busy=%b ovr=%b want 0 0", Frame_Busy, Rx_Overrun);
        end
        p0 = sv_pulses;
        for (int k = 0; k < 6; k++) begin
            strobe(4'd1, fb[k]);
            tick(9);
        end
        #1;
        total++; if (sv_pulses - p0 !== 1 || Temp_Raw !== 16'hBEEF || Humidity_Raw !== 16'h1234) begin
            bad++; $display("FAIL after_reset_frame: got n=%0d %h/%h want n=1 beef/1234", sv_pulses - p0, Temp_Raw, Humidity_Raw);
        end
    endtask

    task automatic test_random();
        logic [7:0] d [6];
        bit took, dummy;
        int p0, s0, dly, mode;
        logic [7:0] junk;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_temp = 16'h0000; m_hum = 16'h0000;
        for (int f = 0; f < 40; f++) begin
            frame_start();
            Master_State_Out = 3'($urandom_range(2, 7));
            model_reset_frame();
            p0 = sv_pulses; s0 = m_samples;
            for (int k = 0; k < 6; k++) d[k] = 8'($urandom);
            d[2] = crc8(d[0], d[1]);
            d[5] = crc8(d[3], d[4]);
            mode = $urandom_range(0, 3);
            if (mode == 1) d[2] ^= 8'($urandom_range(1, 255));
            if (mode == 2) d[5] ^= 8'($urandom_range(1, 255));
            for (int k = 0; k < 6; k++) begin
                strobe(4'($urandom_range(1, 3)), d[k]);
                model_byte(d[k], 1'b0, took);
                if (took && $urandom_range(0, 4) == 0) begin
                    dly = $urandom_range(1, 8);
                    tick(dly - 1);
                    junk = 8'($urandom);
                    strobe(4'($urandom_range(1, 3)), junk);
                    model_byte(junk, 1'b1, dummy);
                    tick(9 - dly);
                end else begin
                    tick(9 + $urandom_range(0, 3));
                end
            end
            #1;
            total++; if (sv_pulses - p0 !== m_samples - s0) begin
                bad++; $display("FAIL rnd_pulses[%0d]: got %0d want %0d", f, sv_pulses - p0, m_samples - s0);
            end
            total++; if (Temp_Raw !== m_temp || Humidity_Raw !== m_hum) begin
                bad++; $display("FAIL rnd_words[%0d]: got %h/%h want %h/%h", f, Temp_Raw, Humidity_Raw, m_temp, m_hum);
            end
            total++; if (CRC_Error_Out !== m_err || Rx_Overrun !== m_ovr) begin
                bad++; $display("FAIL rnd_flags[%0d]: got err=%b ovr=%b want err=%b ovr=%b", f, CRC_Error_Out, Rx_Overrun, m_err, m_ovr);
            end
            total++; if (Frame_Busy !== (m_idx > 0 && m_idx < 6)) begin
                bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", f, Frame_Busy, (m_idx > 0 && m_idx < 6));
            end
        end
        Master_State_Out = 3'b000;
    endtask

    initial begin
        test_reset();
        test_good_frames();
        test_crc_error();
        test_overrun();
        test_start_priority();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
